// File: rtl/vote_pkg.sv
// Shared constants and the serializer state encoding for the vote-result
// UART read-out path.
package vote_pkg;

  localparam int         NUM_CAND       = 4;
  localparam int         FRAME_BYTES    = 6;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer. ready is also high in the final stop-bit cycle,
// so a byte offered then follows with no idle gap.
module uart_tx_byte
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_MAX);
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = 1'b1;

    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    case (state)
      IDLE:  ;
      START: if (bit_end) begin
               state_n   = DATA;
               bit_idx_n = '0;
             end
      DATA:  if (bit_end) begin
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 1'b1;
             end
      STOP:  if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (valid && ready) begin
      state_n = START;
      cnt_n   = '0;
      shreg_n = data;
    end

    // tx is registered from the next-state view so the line never glitches.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: rtl/vote_result_uart_tx.sv
// Snapshots the four candidate tallies on an accepted request and sends
// HEADER, cand1..cand4, XOR checksum as one back-to-back UART frame.
module vote_result_uart_tx
  import vote_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       report_req,
  input  logic [7:0] vote_cand1,
  input  logic [7:0] vote_cand2,
  input  logic [7:0] vote_cand3,
  input  logic [7:0] vote_cand4,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [7:0] snap [NUM_CAND];
  logic [7:0] checksum;
  logic [2:0] byte_idx, next_idx;
  logic [7:0] ser_data;
  logic       accept, last_stop, ser_valid, ser_ready;

  assign accept    = report_req && mode && !busy;
  // While busy the serializer is never idle, so ready marks the last stop cycle.
  assign last_stop = busy && ser_ready;
  assign ser_valid = accept || (last_stop && (byte_idx != LAST_BYTE));
  assign next_idx  = byte_idx + 3'd1;

  // The header goes out straight from acceptance, before the snapshot lands.
  always_comb begin
    ser_data = HEADER;
    if (!accept) begin
      case (next_idx)
        3'd1:    ser_data = snap[0];
        3'd2:    ser_data = snap[1];
        3'd3:    ser_data = snap[2];
        3'd4:    ser_data = snap[3];
        3'd5:    ser_data = checksum;
        default: ser_data = HEADER;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
      // like any other register to keep the frame path fully defined.
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      checksum <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        snap[0]  <= vote_cand1;
        snap[1]  <= vote_cand2;
        snap[2]  <= vote_cand3;
        snap[3]  <= vote_cand4;
        checksum <= vote_cand1 ^ vote_cand2 ^ vote_cand3 ^ vote_cand4;
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (last_stop) begin
        if (byte_idx == LAST_BYTE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          byte_idx <= next_idx;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_vote_result_uart_tx.sv
// Directed bench for vote_result_uart_tx at CLKS_PER_BIT=4 with a UART
// line decoder and busy/done timing monitor.
module tb_vote_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       report_req = 1'b0;
  logic [7:0] vote_cand1 = '0, vote_cand2 = '0, vote_cand3 = '0, vote_cand4 = '0;
  logic       tx, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q [$];
  int stop_err = 0;
  int done_err = 0;
  int done_cnt = 0;
  int busy_run = 0;
  int last_busy_len = 0;
  logic busy_prev = 1'b0;

  vote_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .mode      (mode),
    .report_req(report_req),
    .vote_cand1(vote_cand1),
    .vote_cand2(vote_cand2),
    .vote_cand3(vote_cand3),
    .vote_cand4(vote_cand4),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART line decoder: samples each bit at its centre, on falling clock edges.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) stop_err++;
        q.push_back(b);
      end
    end
  end

  // busy run length, done count, and done only on the cycle busy falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy === 1'b1) busy_run++;
      else if (busy_prev) begin
        last_busy_len = busy_run;
        busy_run      = 0;
      end
      if (done !== (busy_prev && (busy === 1'b0))) done_err++;
      if (done === 1'b1) done_cnt++;
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic set_tally(input logic [7:0] c1, c2, c3, c4);
    vote_cand1 = c1; vote_cand2 = c2; vote_cand3 = c3; vote_cand4 = c4;
  endtask

  task automatic send_req();
    @(negedge clk) report_req = 1'b1;
    @(negedge clk) report_req = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({tag, " ended"}, 32'(n < 2000), 32'd1);
    check({tag, " busy_len"}, last_busy_len, 32'd240);
    check({tag, " done"}, done, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] c1, c2, c3, c4, cs);
    logic [7:0] exp [6];
    exp = '{8'hA5, c1, c2, c3, c4, cs};
    check({tag, " nbytes"}, q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s byte%0d", tag, i),
            (i < q.size()) ? 32'(q[i]) : 32'hDEAD, 32'(exp[i]));
    q.delete();
  endtask

  initial begin
    int bad;
    int dc;

    // Reset state, then 100 idle cycles.
    repeat (3) @(negedge clk);
    check("rst tx", tx, 32'd1);
    check("rst busy", busy, 32'd0);
    check("rst done", done, 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle violations", bad, 32'd0);

    // Basic frame.
    mode = 1'b1;
    set_tally(8'd3, 8'd5, 8'd0, 8'd255);
    dc = done_cnt;
    send_req();
    check("f1 busy start", busy, 32'd1);
    check("f1 tx start", tx, 32'd0);
    wait_end("f1");
    check_frame("f1", 8'h03, 8'h05, 8'h00, 8'hFF, 8'hF9);
    @(negedge clk);
    check("f1 done one cycle", done, 32'd0);
    check("f1 done count", done_cnt - dc, 32'd1);

    // mode=0 request is dropped.
    mode = 1'b0;
    dc = done_cnt;
    send_req();
    bad = 0;
    repeat (50) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("mode0 violations", bad, 32'd0);
    check("mode0 nbytes", q.size(), 32'd0);
    check("mode0 done count", done_cnt - dc, 32'd0);

    // Mid-frame request, tally change and mode drop are all ignored.
    mode = 1'b1;
    set_tally(8'd3, 8'd5, 8'd0, 8'd255);
    dc = done_cnt;
    send_req();
    repeat (3) @(negedge clk);
    report_req = 1'b1;
    @(negedge clk) report_req = 1'b0;
    repeat (80) @(negedge clk);
    vote_cand2 = 8'd9;
    mode = 1'b0;
    wait_end("f2");
    check_frame("f2", 8'h03, 8'h05, 8'h00, 8'hFF, 8'hF9);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("f2 no second frame", bad, 32'd0);
    check("f2 no extra bytes", q.size(), 32'd0);
    check("f2 done count", done_cnt - dc, 32'd1);

    // Asynchronous reset during byte 3.
    mode = 1'b1;
    set_tally(8'd3, 8'd5, 8'd0, 8'd255);
    send_req();
    repeat (125) @(negedge clk);
    dc = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("arst tx", tx, 32'd1);
    check("arst busy", busy, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("arst no done", done_cnt - dc, 32'd0);
    check("arst idle busy", busy, 32'd0);
    q.delete();
    set_tally(8'h12, 8'h34, 8'h56, 8'h78);
    send_req();
    wait_end("f3");
    check_frame("f3", 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);

    // All-zero frame, then back-to-back all-FF request in the done cycle.
    @(negedge clk);
    set_tally(8'h00, 8'h00, 8'h00, 8'h00);
    send_req();
    wait_end("f4");
    check_frame("f4", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_tally(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    report_req = 1'b1;
    @(negedge clk) report_req = 1'b0;
    check("b2b busy", busy, 32'd1);
    check("b2b tx start", tx, 32'd0);
    check("b2b done low", done, 32'd0);
    wait_end("f5");
    check_frame("f5", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    repeat (5) @(negedge clk);

    check("stop bit errors", stop_err, 32'd0);
    check("done timing errors", done_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
